// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM encoding, line level and width helper for the UART transmitter
// Contents:
//   uart_state_t    : transmitter FSM states (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4)
//   UART_IDLE_LEVEL : level driven on the serial line between frames
//   clog2_min1      : ceil(log2(value)), never less than 1, for counter widths
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam logic UART_IDLE_LEVEL = 1'b1;

    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock FIFO with occupancy count
// Ports:
//   clk, rst  : clock (rising edge), asynchronous active-high reset
//   i_push    : write i_data this cycle (caller guarantees not full)
//   i_data    : write data
//   i_pop     : advance the read pointer this cycle (caller guarantees not empty)
//   o_data    : entry at the read pointer (combinational read)
//   o_full    : all DEPTH entries occupied
//   o_empty   : no entries occupied
//   o_count   : occupied entries, 0..DEPTH
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // Pointers are exactly log2(DEPTH) bits so they wrap on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (i_push && !i_pop)
                r_count <= r_count + 1'b1;
            else if (i_pop && !i_push)
                r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered UART transmitter: valid/ready byte input, FIFO, baud-timed serialiser
// Optional feature macro: UART_TX_PARITY_EN (adds parity_odd input and a parity bit per frame)
// Ports:
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   s_data     : byte to send; only s_data[DATA_BITS-1:0] goes on the line
//   s_valid    : s_data valid; pushed on an edge where s_valid && s_ready
//   s_ready    : FIFO not full (from registered count only)
//   parity_odd : (UART_TX_PARITY_EN only) odd parity when 1, sampled at pop
//   tx_out     : serial line, idle high, LSB first
//   tx_busy    : frame in progress
//   tx_done    : one-cycle pulse during the last cycle of each frame
//   fifo_count : occupied FIFO entries
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = 100,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
`ifdef UART_TX_PARITY_EN
    input  logic                          parity_odd,
`endif
    output logic                          tx_out,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int BW = clog2_min1(BAUD_DIV);
    localparam int NW = clog2_min1(DATA_BITS);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] BAUD_PRE  = BW'(BAUD_DIV - 2);
    localparam logic [NW-1:0] DATA_LAST = NW'(DATA_BITS - 1);
    localparam logic [NW-1:0] STOP_LAST = NW'(STOP_BITS - 1);

    logic                 w_push;
    logic                 w_pop;
    logic                 w_load;
    logic                 w_full;
    logic                 w_empty;
    logic [DATA_BITS-1:0] w_fifo_data;

    uart_state_t          r_state,  w_state_nxt;
    logic [BW-1:0]        r_baud,   w_baud_nxt;
    logic [NW-1:0]        r_bit,    w_bit_nxt;
    logic [DATA_BITS-1:0] r_shift,  w_shift_nxt;
    logic                 r_tx_out, w_tx_nxt;
    logic                 r_busy,   w_busy_nxt;
    logic                 r_done,   w_done_nxt;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity, w_parity_nxt;
`endif

    assign w_push  = s_valid && s_ready;
    assign s_ready = !w_full;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (s_data[DATA_BITS-1:0]),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_tx_out <= UART_IDLE_LEVEL;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_baud   <= w_baud_nxt;
            r_bit    <= w_bit_nxt;
            r_shift  <= w_shift_nxt;
            r_tx_out <= w_tx_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
`ifdef UART_TX_PARITY_EN
            r_parity <= w_parity_nxt;
`endif
        end
    end

    // Next-state logic computes the value every output register takes at the
    // coming edge, so the line, busy and done all change on the transition edge.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud + 1'b1;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx_out;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_pop       = 1'b0;
        w_load      = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_parity_nxt = r_parity;
`endif
        case (r_state)
            IDLE: begin
                w_baud_nxt = r_baud;
                w_tx_nxt   = UART_IDLE_LEVEL;
                w_busy_nxt = 1'b0;
                if (!w_empty) w_load = 1'b1;
            end
            START: begin
                if (r_baud == BAUD_LAST) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = DATA;
                    w_tx_nxt    = r_shift[0];
                end
            end
            DATA: begin
                if (r_baud == BAUD_LAST) begin
                    w_baud_nxt = '0;
                    if (r_bit == DATA_LAST) begin
                        w_bit_nxt = '0;
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = PARITY;
                        w_tx_nxt    = r_parity;
`else
                        w_state_nxt = STOP;
                        w_tx_nxt    = UART_IDLE_LEVEL;
`endif
                    end else begin
                        w_bit_nxt   = r_bit + 1'b1;
                        w_shift_nxt = r_shift >> 1;
                        w_tx_nxt    = r_shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (r_baud == BAUD_LAST) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = STOP;
                    w_tx_nxt    = UART_IDLE_LEVEL;
                end
            end
`endif
            STOP: begin
                // The baud counter only spans one bit; r_bit counts stop bits.
                // Done is registered one cycle early so it is high during the last cycle.
                if (r_bit == STOP_LAST && r_baud == BAUD_PRE) w_done_nxt = 1'b1;
                if (r_baud == BAUD_LAST) begin
                    w_baud_nxt = '0;
                    if (r_bit == STOP_LAST) begin
                        w_bit_nxt = '0;
                        if (!w_empty) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_nxt = IDLE;
                            w_busy_nxt  = 1'b0;
                        end
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_baud_nxt  = '0;
                w_bit_nxt   = '0;
                w_tx_nxt    = UART_IDLE_LEVEL;
                w_busy_nxt  = 1'b0;
            end
        endcase

        // Shared by IDLE and end-of-STOP: pop straight into a start bit.
        if (w_load) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_fifo_data;
            w_baud_nxt  = '0;
            w_bit_nxt   = '0;
            w_state_nxt = START;
            w_tx_nxt    = 1'b0;
            w_busy_nxt  = 1'b1;
`ifdef UART_TX_PARITY_EN
            w_parity_nxt = (^w_fifo_data) ^ parity_odd;
`endif
        end
    end

    assign tx_out  = r_tx_out;
    assign tx_busy = r_busy;
    assign tx_done = r_done;

endmodule
